// File: rtl/axis_iq_packer_if.sv
// axis_iq_packer_if: AXI-Stream bundle for the IQ packer's input and output streams
interface axis_iq_packer_if #(
  parameter int DW = 32,
  parameter int KW = 1
);
  logic [DW-1:0] tdata;
  logic [KW-1:0] tkeep;
  logic          tlast;
  logic          tvalid;
  logic          tready;
  modport master (output tdata, tkeep, tlast, tvalid, input tready);
  modport slave  (input tdata, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_iq_packer.sv
// axis_iq_packer: quantises 2x16-bit IQ samples and packs PACK lanes per output word, MSB lane first
module axis_iq_packer #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_BITS  = 4,
  parameter int OUT_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    round_en,
  axis_iq_packer_if.slave         i_axis,
  axis_iq_packer_if.master        o_axis,
  output logic [15:0]             sat_count
);
  localparam int H    = IN_WIDTH / 2;
  localparam int S    = H - OUT_BITS;
  localparam int LW   = 2 * OUT_BITS;
  localparam int PACK = OUT_WIDTH / LW;
  localparam int KB   = $clog2(PACK);
  localparam logic signed [H:0] RC   = (S > 0) ? (H+1)'(1) << (S > 0 ? S - 1 : 0) : '0;
  localparam logic signed [H:0] QMAX = (H+1)'((1 << (OUT_BITS - 1)) - 1);
  localparam logic signed [H:0] QMIN = -QMAX - (H+1)'(1);
  logic [KB-1:0]        r_k;
  logic [OUT_WIDTH-1:0] r_acc;
  logic [OUT_WIDTH-1:0] r_data;
  logic [PACK-1:0]      r_keep;
  logic                 r_last;
  logic                 r_valid;
  logic [OUT_BITS:0]    w_qi;
  logic [OUT_BITS:0]    w_qq;
  logic [LW-1:0]        w_lane;
  logic [1:0]           w_nsat;
  logic                 w_complete;
  logic                 w_fire;
  logic [OUT_WIDTH-1:0] w_merged;
  logic [PACK-1:0]      w_keep;
  logic [16:0]          w_sat_sum;
  // Returns {clamped, q}: truncate keeps the top bits, round adds half an LSB at H+1 bits then clamps
  function automatic logic [OUT_BITS:0] quant(input logic [H-1:0] c, input logic rnd);
    logic signed [H:0] r;
    r = $signed({c[H-1], c}) + RC;
    r = r >>> S;
    if (!rnd) return {1'b0, c[H-1:S]};
    if (r > QMAX) return {1'b1, QMAX[OUT_BITS-1:0]};
    if (r < QMIN) return {1'b1, QMIN[OUT_BITS-1:0]};
    return {1'b0, r[OUT_BITS-1:0]};
  endfunction
  // Quantise the current beat, merge it into the word being built and decide acceptance
  always_comb begin
    w_qi       = quant(i_axis.tdata[IN_WIDTH-1:H], round_en);
    w_qq       = quant(i_axis.tdata[H-1:0], round_en);
    w_lane     = {w_qi[OUT_BITS-1:0], w_qq[OUT_BITS-1:0]};
    w_nsat     = 2'(w_qi[OUT_BITS]) + 2'(w_qq[OUT_BITS]);
    w_sat_sum  = 17'(sat_count) + 17'(w_nsat);
    w_complete = (r_k == KB'(PACK - 1)) || i_axis.tlast;
    w_merged   = r_acc | (OUT_WIDTH'(w_lane) << (LW * (PACK - 1 - int'(r_k))));
    w_keep     = ~({PACK{1'b1}} >> (int'(r_k) + 1));
    i_axis.tready = !(r_valid && !o_axis.tready && w_complete);
    w_fire     = i_axis.tvalid && i_axis.tready;
  end
  // Lane accumulator and output register; a completing beat reloads the output even as it drains
  always_ff @(posedge clk) begin
    if (reset) begin
      r_k     <= '0;
      r_acc   <= '0;
      r_data  <= '0;
      r_keep  <= '0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
    end else if (w_fire && w_complete) begin
      r_data  <= w_merged;
      r_keep  <= w_keep;
      r_last  <= i_axis.tlast;
      r_valid <= 1'b1;
      r_k     <= '0;
      r_acc   <= '0;
    end else begin
      if (o_axis.tready) r_valid <= 1'b0;
      if (w_fire) begin
        r_acc <= w_merged;
        r_k   <= r_k + KB'(1);
      end
    end
  end
  // Saturating count of clamped components over accepted beats
  always_ff @(posedge clk) begin
    if (reset) sat_count <= '0;
    else if (w_fire) sat_count <= w_sat_sum[16] ? 16'hFFFF : w_sat_sum[15:0];
  end
  assign o_axis.tdata  = r_data;
  assign o_axis.tkeep  = r_keep;
  assign o_axis.tlast  = r_last;
  assign o_axis.tvalid = r_valid;
endmodule

// File: tb/tb_axis_iq_packer.sv
// tb_axis_iq_packer: scoreboard bench for the IQ quantiser/packer
module tb_axis_iq_packer;
  localparam int S = 12;
  typedef struct packed {logic [31:0] d; logic [3:0] k; logic l;} word_t;
  logic clk = 0;
  logic reset = 1;
  logic round_en = 0;
  logic [15:0] sat_count;
  logic rdy_dir = 1;
  logic rdy_rnd = 0;
  bit rnd_rdy = 0;
  axis_iq_packer_if #(.DW(32), .KW(1)) in_if();
  axis_iq_packer_if #(.DW(32), .KW(4)) out_if();
  axis_iq_packer #(.IN_WIDTH(32), .OUT_BITS(4), .OUT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .round_en(round_en),
    .i_axis(in_if), .o_axis(out_if), .sat_count(sat_count)
  );
  assign out_if.tready = rnd_rdy ? rdy_rnd : rdy_dir;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1 rdy_rnd = 1'($urandom_range(0, 1));
  end
  word_t q[$];
  word_t mon_w;
  word_t last_push;
  int checks = 0;
  int errors = 0;
  int mk = 0;
  logic [31:0] macc = 0;
  int exp_sat = 0;
  int popped = 0;
  logic [31:0] held;
  int pstart;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [3:0] qc(input int c, input bit rnd, inout int ns);
    int v;
    v = rnd ? (c + (1 << (S - 1))) >>> S : c >>> S;
    if (rnd && v > 7) begin v = 7; ns++; end
    if (rnd && v < -8) begin v = -8; ns++; end
    return 4'(v);
  endfunction
  task automatic model(input logic [31:0] d, input bit last, input bit rnd);
    int ns = 0;
    logic [7:0] lane;
    word_t w;
    lane = {qc(int'($signed(d[31:16])), rnd, ns), qc(int'($signed(d[15:0])), rnd, ns)};
    macc |= 32'(lane) << (8 * (3 - mk));
    exp_sat = (exp_sat + ns > 65535) ? 65535 : exp_sat + ns;
    if (mk == 3 || last) begin
      w.d = macc; w.k = 4'b1111 << (3 - mk); w.l = last;
      q.push_back(w); last_push = w;
      macc = 0; mk = 0;
    end else mk++;
  endtask
  task automatic send(input logic [31:0] d, input bit last, input bit rnd);
    int n = 0;
    in_if.tdata = d; in_if.tlast = last; in_if.tvalid = 1; round_en = rnd;
    @(negedge clk);
    while (!in_if.tready && n < 200) begin n++; @(negedge clk); end
    if (!in_if.tready) chk("send_timeout", 0, 1);
    else model(d, last, rnd);
    @(posedge clk); #1;
    in_if.tvalid = 0; in_if.tlast = 0;
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 1000) begin @(negedge clk); n++; end
    chk("drain", 32'(q.size()), 0);
    @(posedge clk); #1;
  endtask
  always @(negedge clk) begin
    if (!reset && out_if.tvalid && out_if.tready) begin
      if (q.size() == 0) chk("unexpected_word", 1, 0);
      else begin
        mon_w = q.pop_front();
        chk("tdata", out_if.tdata, mon_w.d);
        chk("tkeep", 32'(out_if.tkeep), 32'(mon_w.k));
        chk("tlast", 32'(out_if.tlast), 32'(mon_w.l));
        popped++;
      end
    end
  end
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tvalid"}, 32'(out_if.tvalid), 0);
    chk({tag, "_tdata"}, out_if.tdata, 0);
    chk({tag, "_tkeep"}, 32'(out_if.tkeep), 0);
    chk({tag, "_tlast"}, 32'(out_if.tlast), 0);
    chk({tag, "_sat"}, 32'(sat_count), 0);
  endtask
  initial begin
    in_if.tvalid = 0; in_if.tdata = 0; in_if.tlast = 0; in_if.tkeep = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk); #1 reset = 0;
    send(32'h7FFF8000, 0, 0);
    send(32'h12340000, 0, 0);
    send(32'hFFFF0001, 0, 0);
    send(32'h00000000, 1, 0);
    @(negedge clk);
    chk("lat_valid", 32'(out_if.tvalid), 1);
    drain();
    for (int i = 0; i < 4; i++) send(32'h7FFF7000, i == 3, 1);
    drain();
    chk("sat_round", 32'(sat_count), 32'(exp_sat));
    send(32'h10002000, 0, 0);
    send(32'h10002000, 1, 0);
    drain();
    rdy_dir = 0;
    for (int i = 0; i < 4; i++) send(32'h11112222 * (i + 1), i == 3, 0);
    held = last_push.d;
    for (int i = 0; i < 3; i++) send(32'h40003000 + i, 0, 0);
    fork
      send(32'h7000C000, 0, 0);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("bp_ready", 32'(in_if.tready), 0);
          chk("bp_valid", 32'(out_if.tvalid), 1);
          chk("bp_hold", out_if.tdata, held);
        end
        @(posedge clk); #1 rdy_dir = 1;
      end
    join
    @(negedge clk);
    chk("bp_next_valid", 32'(out_if.tvalid), 1);
    drain();
    pstart = popped;
    for (int i = 0; i < 16; i++) send($urandom, 0, 1'($urandom_range(0, 1)));
    drain();
    chk("stream_words", 32'(popped - pstart), 4);
    send(32'h12345678, 0, 0);
    send(32'h9ABCDEF0, 0, 0);
    reset = 1;
    mk = 0; macc = 0; exp_sat = 0; q.delete();
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk); #1 reset = 0;
    for (int i = 0; i < 4; i++) send(32'h0F00F000 + 32'(i) * 32'h10001000, i == 3, 0);
    drain();
    chk("post_rst_sat", 32'(sat_count), 32'(exp_sat));
    rnd_rdy = 1;
    for (int i = 0; i < 10000; i++) send($urandom, $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)));
    drain();
    rnd_rdy = 0;
    chk("rand_sat", 32'(sat_count), 32'(exp_sat));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
